// File: rtl/mem_256x16_arb.sv
// Two-requester round-robin arbiter and access sequencer for a shared
// 256x16 memory. The block grants one requester in IDLE, then spends one
// ACCESS cycle driving the memory. Read data returns registered, together
// with a one-cycle valid pulse.
module mem_256x16_arb #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          wr_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    output logic [DW-1:0] rdata_a,
    output logic          rvalid_a,
    input  logic          req_b,
    input  logic          wr_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic [DW-1:0] rdata_b,
    output logic          rvalid_b,
    output logic          mem_port_sel,
    output logic          mem_we_a,
    output logic          mem_we_b,
    output logic [AW-1:0] mem_addr_wa,
    output logic [AW-1:0] mem_addr_wb,
    output logic [DW-1:0] mem_data_wa,
    output logic [DW-1:0] mem_data_wb,
    input  logic [DW-1:0] mem_data_q,
    output logic [CW-1:0] cnt_a,
    output logic [CW-1:0] cnt_b,
    output logic          busy
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_last_b;    // 1 when the most recent grant went to B
    logic            r_sel;
    logic            r_wr;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;

    logic            w_idle;
    logic            w_win_b;
    logic            w_xfer;
    logic            w_rd_done;
    logic [1:0]      w_gnt_v;

    assign w_idle = (r_state == S_IDLE);

    // B wins when it is the only requester, or on a tie when A went last.
    assign w_win_b = req_b && (!req_a || !r_last_b);

    assign gnt_a   = w_idle && !rst && req_a && !w_win_b;
    assign gnt_b   = w_idle && !rst && w_win_b;
    assign w_gnt_v = {gnt_b, gnt_a};
    assign w_xfer  = gnt_a || gnt_b;

    // A read completes at the edge that ends ACCESS; reset takes priority there.
    assign w_rd_done = (r_state == S_ACCESS) && !r_wr;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a grant opens one ACCESS cycle, which always ends.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_xfer) w_state_next = S_ACCESS;
            S_ACCESS: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Latch the winning command and remember who was granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_b <= 1'b1;
            r_sel    <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_xfer) begin
            r_last_b <= gnt_b;
            r_sel    <= gnt_b;
            r_wr     <= gnt_b ? wr_b    : wr_a;
            r_addr   <= gnt_b ? addr_b  : addr_a;
            r_wdata  <= gnt_b ? wdata_b : wdata_a;
        end
    end

    // Memory drive: only the selected port is active, and only during ACCESS.
    always_comb begin
        busy         = 1'b0;
        mem_port_sel = 1'b0;
        mem_we_a     = 1'b0;
        mem_we_b     = 1'b0;
        mem_addr_wa  = '0;
        mem_addr_wb  = '0;
        mem_data_wa  = '0;
        mem_data_wb  = '0;
        if (r_state == S_ACCESS) begin
            busy         = 1'b1;
            mem_port_sel = r_sel;
            if (r_sel) begin
                mem_we_b    = r_wr && !rst;
                mem_addr_wb = r_addr;
                mem_data_wb = r_wdata;
            end else begin
                mem_we_a    = r_wr && !rst;
                mem_addr_wa = r_addr;
                mem_data_wa = r_wdata;
            end
        end
    end

    // Per-requester grant counter and read-return path (0 = A, 1 = B).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [CW-1:0] r_cnt;
            logic [DW-1:0] r_rdata;
            logic          r_rvalid;

            // Count grants without wrapping; capture read data for this side.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt    <= '0;
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= 1'b0;
                    if (w_gnt_v[gi] && (r_cnt != {CW{1'b1}})) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_rd_done && (r_sel == 1'(gi))) begin
                        r_rdata  <= mem_data_q;
                        r_rvalid <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign cnt_a    = g_chan[0].r_cnt;
    assign cnt_b    = g_chan[1].r_cnt;
    assign rdata_a  = g_chan[0].r_rdata;
    assign rdata_b  = g_chan[1].r_rdata;
    assign rvalid_a = g_chan[0].r_rvalid;
    assign rvalid_b = g_chan[1].r_rvalid;

endmodule

// File: tb/tb_mem_256x16_arb.sv
// Bench for mem_256x16_arb: a behavioural 256x16 memory, directed scenarios,
// and a read-data scoreboard drained by an independent monitor process.
module tb_mem_256x16_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0, wr_a = 1'b0, req_b = 1'b0, wr_b = 1'b0;
    logic [7:0]  addr_a = '0, addr_b = '0;
    logic [15:0] wdata_a = '0, wdata_b = '0;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [15:0] rdata_a, rdata_b;
    logic        mem_port_sel, mem_we_a, mem_we_b;
    logic [7:0]  mem_addr_wa, mem_addr_wb;
    logic [15:0] mem_data_wa, mem_data_wb, mem_data_q;
    logic [15:0] cnt_a, cnt_b;
    logic        busy;

    // Small-counter instance used only for the saturation scenario.
    logic        s_req_a = 1'b0;
    logic        s_gnt_a, s_gnt_b, s_rvalid_a, s_rvalid_b, s_sel, s_we_a, s_we_b, s_busy;
    logic [15:0] s_rdata_a, s_rdata_b, s_data_wa, s_data_wb;
    logic [7:0]  s_addr_wa, s_addr_wb;
    logic [2:0]  s_cnt_a, s_cnt_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic        side;
        logic [15:0] data;
        int          due;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    logic [15:0] mem [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_256x16_arb dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
        .mem_port_sel(mem_port_sel), .mem_we_a(mem_we_a), .mem_we_b(mem_we_b),
        .mem_addr_wa(mem_addr_wa), .mem_addr_wb(mem_addr_wb),
        .mem_data_wa(mem_data_wa), .mem_data_wb(mem_data_wb),
        .mem_data_q(mem_data_q), .cnt_a(cnt_a), .cnt_b(cnt_b), .busy(busy)
    );

    mem_256x16_arb #(.AW(8), .DW(16), .CW(3)) dut_sat (
        .clk(clk), .rst(rst),
        .req_a(s_req_a), .wr_a(1'b1), .addr_a(8'h00), .wdata_a(16'h0000),
        .gnt_a(s_gnt_a), .rdata_a(s_rdata_a), .rvalid_a(s_rvalid_a),
        .req_b(1'b0), .wr_b(1'b0), .addr_b(8'h00), .wdata_b(16'h0000),
        .gnt_b(s_gnt_b), .rdata_b(s_rdata_b), .rvalid_b(s_rvalid_b),
        .mem_port_sel(s_sel), .mem_we_a(s_we_a), .mem_we_b(s_we_b),
        .mem_addr_wa(s_addr_wa), .mem_addr_wb(s_addr_wb),
        .mem_data_wa(s_data_wa), .mem_data_wb(s_data_wb),
        .mem_data_q(16'h0000), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b), .busy(s_busy)
    );

    // Behavioural memory: synchronous write, combinational read of the selected port.
    initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    always @(posedge clk) begin
        if (mem_we_a) mem[mem_addr_wa] <= mem_data_wa;
        if (mem_we_b) mem[mem_addr_wb] <= mem_data_wb;
    end
    assign mem_data_q = mem_port_sel ? mem[mem_addr_wb] : mem[mem_addr_wa];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pop one expectation per rvalid pulse and compare side, data, timing.
    task automatic pop_check(input logic side, input logic [15:0] data);
        rd_exp_t e;
        if (exp_q.size() == 0) begin
            chk("spurious_rvalid", 32'(1'b1), 32'(1'b0));
        end else begin
            e = exp_q.pop_front();
            chk("rd_side", 32'(side), 32'(e.side));
            chk("rd_data", 32'(data), 32'(e.data));
            chk("rd_latency", 32'(cyc), 32'(e.due));
            $display("read side=%0d data=0x%04h expected=0x%04h cycle=%0d", side, data, e.data, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rvalid_a) pop_check(1'b0, rdata_a);
            if (rvalid_b) pop_check(1'b1, rdata_b);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; s_req_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction from one side; called and returns at a falling edge in IDLE.
    task automatic txn(input logic side, input logic wr, input logic [7:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp_rd);
        int  waited = 0;
        logic g;
        rd_exp_t e;
        if (side) begin req_b = 1'b1; wr_b = wr; addr_b = addr; wdata_b = wd; end
        else      begin req_a = 1'b1; wr_a = wr; addr_a = addr; wdata_a = wd; end
        #1;
        g = side ? gnt_b : gnt_a;
        while (!g && waited < 8) begin
            @(negedge clk); #1; waited++;
            g = side ? gnt_b : gnt_a;
        end
        chk("gnt_wait", 32'(waited), 32'd0);
        chk("idle_we", 32'({mem_we_a, mem_we_b}), 32'd0);
        if (!wr) begin
            e.side = side; e.data = exp_rd; e.due = cyc + 2;
            exp_q.push_back(e);
        end
        $display("txn side=%0d wr=%0d addr=0x%02h wdata=0x%04h cycle=%0d", side, wr, addr, wd, cyc);
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        #1;
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_sel", 32'(mem_port_sel), 32'(side));
        chk("acc_we_sel", 32'(side ? mem_we_b : mem_we_a), 32'(wr));
        chk("acc_we_other", 32'(side ? mem_we_a : mem_we_b), 32'd0);
        chk("acc_addr", 32'(side ? mem_addr_wb : mem_addr_wa), 32'(addr));
        chk("acc_addr_other", 32'(side ? mem_addr_wa : mem_addr_wb), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rd_exp_t e;
        bit      ea, eb;

        // Reset state
        do_reset();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_rdata_a", 32'(rdata_a), 32'd0);
        chk("rst_mem", 32'({mem_port_sel, mem_we_a, mem_we_b, mem_addr_wa, mem_addr_wb}), 32'd0);
        @(negedge clk);

        // A write then read of 0x12
        txn(1'b0, 1'b1, 8'h12, 16'hBEEF, 16'h0000);
        txn(1'b0, 1'b0, 8'h12, 16'h0000, 16'hBEEF);
        #1;
        chk("cnt_a_two", 32'(cnt_a), 32'd2);
        @(negedge clk);

        // Both requesters held: grants alternate A, B every other cycle
        txn(1'b1, 1'b1, 8'h01, 16'h1111, 16'h0000);
        txn(1'b0, 1'b1, 8'h02, 16'h2222, 16'h0000);
        do_reset();
        req_a = 1'b1; wr_a = 1'b0; addr_a = 8'h01;
        req_b = 1'b1; wr_b = 1'b0; addr_b = 8'h02;
        for (int k = 0; k < 8; k++) begin
            #1;
            ea = (k % 4 == 0);
            eb = (k % 4 == 2);
            chk("rr_gnt_a", 32'(gnt_a), 32'(ea));
            chk("rr_gnt_b", 32'(gnt_b), 32'(eb));
            if (k % 2 == 1) chk("rr_sel", 32'(mem_port_sel), 32'(k % 4 == 3));
            if (gnt_a) begin e.side = 1'b0; e.data = 16'h1111; e.due = cyc + 2; exp_q.push_back(e); end
            if (gnt_b) begin e.side = 1'b1; e.data = 16'h2222; e.due = cyc + 2; exp_q.push_back(e); end
            @(negedge clk);
        end
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        #1;
        chk("rr_cnt_b", 32'(cnt_b), 32'd2);
        @(negedge clk);

        // Same-cycle A read / B write of 0xFF after reset: A first sees old data
        do_reset();
        req_a = 1'b1; wr_a = 1'b0; addr_a = 8'hFF;
        req_b = 1'b1; wr_b = 1'b1; addr_b = 8'hFF; wdata_b = 16'h1234;
        #1;
        chk("tie_gnt_a", 32'({gnt_a, gnt_b}), 32'b10);
        e.side = 1'b0; e.data = 16'h0000; e.due = cyc + 2; exp_q.push_back(e);
        @(negedge clk);
        req_a = 1'b0;
        #1;
        chk("held_req_ignored", 32'(gnt_b), 32'd0);
        @(negedge clk);
        #1;
        chk("tie_gnt_b", 32'({gnt_a, gnt_b}), 32'b01);
        @(negedge clk);
        req_b = 1'b0;
        #1;
        chk("tie_we_b", 32'({mem_we_a, mem_we_b}), 32'b01);
        @(negedge clk);
        txn(1'b0, 1'b0, 8'hFF, 16'h0000, 16'h1234);

        // Reset during the ACCESS cycle of a B write
        do_reset();
        txn(1'b1, 1'b1, 8'h40, 16'h5555, 16'h0000);
        txn(1'b0, 1'b0, 8'h40, 16'h0000, 16'h5555);
        req_b = 1'b1; wr_b = 1'b1; addr_b = 8'h40; wdata_b = 16'hAAAA;
        #1;
        chk("rstacc_gnt_b", 32'(gnt_b), 32'd1);
        @(negedge clk);
        req_b = 1'b0; rst = 1'b1;
        #1;
        chk("rstacc_we_b", 32'(mem_we_b), 32'd0);
        @(negedge clk);
        #1;
        chk("rstacc_gnt_forced", 32'(gnt_a), 32'd0);
        chk("rstacc_busy", 32'(busy), 32'd0);
        chk("rstacc_cnts", 32'({cnt_a, cnt_b}), 32'd0);
        chk("rstacc_rdata", 32'({rdata_a, rdata_b}), 32'd0);
        chk("rstacc_rvalid", 32'({rvalid_a, rvalid_b}), 32'd0);
        chk("rstacc_mem", 32'({mem_port_sel, mem_we_a, mem_we_b, mem_addr_wb, mem_data_wb[7:0]}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn(1'b0, 1'b0, 8'h40, 16'h0000, 16'h5555);

        // Boundary addresses on both ports
        txn(1'b0, 1'b1, 8'h00, 16'h0A0A, 16'h0000);
        txn(1'b1, 1'b1, 8'hFF, 16'hB0B0, 16'h0000);
        txn(1'b1, 1'b0, 8'h00, 16'h0000, 16'h0A0A);
        txn(1'b0, 1'b0, 8'hFF, 16'h0000, 16'hB0B0);
        txn(1'b0, 1'b1, 8'hFF, 16'hF00F, 16'h0000);
        txn(1'b1, 1'b0, 8'hFF, 16'h0000, 16'hF00F);

        // Counter saturation on the 3-bit instance with A held continuously
        s_req_a = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("sat_cnt_mid", 32'(s_cnt_a), 32'd6);
        repeat (28) @(negedge clk);
        #1;
        chk("sat_cnt_end", 32'(s_cnt_a), 32'd7);
        $display("saturation cnt=%0d cycle=%0d", s_cnt_a, cyc);
        s_req_a = 1'b0;

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
